// File: rtl/agc_control_sequencer.sv
// AGC control-pulse sequencer: fetches an instruction into B, decodes it and
// issues one register-write strobe per cycle together with its mux selects and ALU op.
module agc_control_sequencer #(
  parameter int MEM_WAIT        = 0,
  parameter int STEP_W          = 4,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] qc,
  input  logic       extracode,
  input  logic       mem_ready,
  input  logic       run,
  input  logic       step,
  output logic       mem_wr,
  output logic       lp_wr,
  output logic       g_wr,
  output logic       q_wr,
  output logic       b_wr,
  output logic       a_wr,
  output logic       y_wr,
  output logic       x_wr,
  output logic       z_wr,
  output logic       maddr_mux,
  output logic       mdata_mux,
  output logic       lp_mux,
  output logic       g_mux,
  output logic       b_mux,
  output logic [1:0] q_mux,
  output logic [1:0] a_mux,
  output logic [1:0] x_mux,
  output logic [1:0] z_mux,
  output logic [2:0] y_mux,
  output logic [2:0] alu_op,
  output logic       ext_flag,
  output logic       busy,
  output logic       instr_done,
  output logic       illegal
);

  localparam int WAIT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT);

  localparam int W_MEM = 8, W_LP = 7, W_G = 6, W_Q = 5, W_B = 4, W_A = 3, W_Y = 2, W_X = 1, W_Z = 0;

  localparam logic [2:0] ALU_AD = 3'd0, ALU_SU = 3'd1, ALU_MASK = 3'd2, ALU_MP0 = 3'd3,
                         ALU_MP1 = 3'd4, ALU_DV0 = 3'd5, ALU_DV1 = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  typedef enum logic [3:0] {I_TC, I_CCS, I_INDEX, I_XCH, I_CS, I_TS, I_AD, I_MASK, I_SU,
                            I_MP, I_DV, I_EXT, I_ILL} instr_t;

  state_t              state_q;
  instr_t              instr_q, instr_d;
  logic [STEP_W-1:0]   step_q, tail_start_s, tail_idx_s, last_s;
  logic                tail_en_s;
  logic [WAIT_W-1:0]   wait_q;
  logic [8:0]          stb_q;
  logic                maddr_mux_q, mdata_mux_q, lp_mux_q, g_mux_q, b_mux_q;
  logic [1:0]          q_mux_q, a_mux_q, x_mux_q, z_mux_q;
  logic [2:0]          y_mux_q, alu_op_q;
  logic                ext_flag_q, busy_q, instr_done_q, illegal_q;

  assign {mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr} = stb_q;
  assign {maddr_mux, mdata_mux, lp_mux, g_mux, b_mux} = {maddr_mux_q, mdata_mux_q, lp_mux_q, g_mux_q, b_mux_q};
  assign {q_mux, a_mux, x_mux, z_mux, y_mux, alu_op} = {q_mux_q, a_mux_q, x_mux_q, z_mux_q, y_mux_q, alu_op_q};
  assign {ext_flag, busy, instr_done, illegal} = {ext_flag_q, busy_q, instr_done_q, illegal_q};

  // Instruction decode; the opcode-5/qc-1 EXTEND wins regardless of extracode.
  always_comb begin
    instr_d = I_ILL;
    if (opcode == 3'd5 && qc == 2'd1) begin
      instr_d = I_EXT;
    end else if (!extracode) begin
      case (opcode)
        3'd0:    instr_d = I_TC;
        3'd1:    instr_d = I_CCS;
        3'd4:    instr_d = I_CS;
        3'd6:    instr_d = I_AD;
        3'd7:    instr_d = I_MASK;
        3'd5:    instr_d = (qc == 2'd0) ? I_INDEX : ((qc == 2'd2) ? I_TS : I_XCH);
        default: instr_d = I_ILL;
      endcase
    end else begin
      case (opcode)
        3'd6:    instr_d = I_SU;
        3'd7:    instr_d = I_MP;
        3'd1:    instr_d = I_DV;
        default: instr_d = I_ILL;
      endcase
    end
  end

  // Where the shared x/y/z tail begins and which step ends each instruction.
  always_comb begin
    tail_en_s    = 1'b1;
    tail_start_s = STEP_W'(0);
    last_s       = STEP_W'(0);
    case (instr_q)
      I_TC, I_CS:               begin tail_start_s = STEP_W'(2); last_s = STEP_W'(4);  end
      I_TS:                     begin tail_start_s = STEP_W'(1); last_s = STEP_W'(3);  end
      I_XCH, I_AD, I_MASK, I_SU: begin tail_start_s = STEP_W'(3); last_s = STEP_W'(5);  end
      I_MP, I_DV:               begin tail_start_s = STEP_W'(4); last_s = STEP_W'(6);  end
      I_INDEX:                  begin tail_start_s = STEP_W'(8); last_s = STEP_W'(10); end
      I_CCS:                    begin tail_en_s = 1'b0;          last_s = STEP_W'(6);  end
      default:                  begin tail_en_s = 1'b0;          last_s = STEP_W'(0);  end
    endcase
    tail_idx_s = step_q - tail_start_s;
  end

  // Sequencer FSM with all outputs registered; strobes self-clear, selects hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  instr_q <= I_TC;  step_q <= '0;  wait_q <= '0;  stb_q <= '0;
      maddr_mux_q <= 1'b0;  mdata_mux_q <= 1'b0;  lp_mux_q <= 1'b0;  g_mux_q <= 1'b0;  b_mux_q <= 1'b0;
      q_mux_q <= 2'd0;  a_mux_q <= 2'd0;  x_mux_q <= 2'd0;  z_mux_q <= 2'd0;
      y_mux_q <= 3'd0;  alu_op_q <= 3'd0;
      ext_flag_q <= 1'b0;  busy_q <= 1'b0;  instr_done_q <= 1'b0;  illegal_q <= 1'b0;
    end else begin
      stb_q        <= '0;
      instr_done_q <= 1'b0;
      illegal_q    <= HALT_ON_ILLEGAL ? illegal_q : 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run || step) begin
            state_q <= S_FETCH;  wait_q <= '0;  busy_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (wait_q == WAIT_MAX && mem_ready) begin
            stb_q[W_B] <= 1'b1;  maddr_mux_q <= 1'b0;  b_mux_q <= 1'b0;  state_q <= S_DECODE;
          end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (instr_d == I_ILL) begin
            illegal_q <= 1'b1;
            if (HALT_ON_ILLEGAL) begin
              state_q <= S_HALT;  busy_q <= 1'b0;
            end else begin
              state_q <= S_FETCH;  wait_q <= '0;
            end
          end else begin
            instr_q <= instr_d;  step_q <= '0;  state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (tail_en_s && (step_q >= tail_start_s)) begin
            case (tail_idx_s)
              STEP_W'(0): begin stb_q[W_X] <= 1'b1; x_mux_q <= 2'd1; ext_flag_q <= 1'b0; end
              STEP_W'(1): begin stb_q[W_Y] <= 1'b1; y_mux_q <= 3'd2; end
              default:    begin stb_q[W_Z] <= 1'b1; z_mux_q <= 2'd1; alu_op_q <= ALU_AD; end
            endcase
          end else begin
            case (instr_q)
              I_TC: begin
                if (step_q == STEP_W'(0)) begin stb_q[W_Q] <= 1'b1; q_mux_q <= 2'd2; end
                else begin stb_q[W_Z] <= 1'b1; z_mux_q <= 2'd2; end
              end
              I_CCS: begin
                case (step_q)
                  STEP_W'(0): begin stb_q[W_A] <= 1'b1; maddr_mux_q <= 1'b1; a_mux_q <= 2'd0; end
                  STEP_W'(1): begin stb_q[W_Y] <= 1'b1; y_mux_q <= 3'd3; end
                  STEP_W'(2): begin stb_q[W_X] <= 1'b1; x_mux_q <= 2'd2; end
                  STEP_W'(3): begin stb_q[W_Z] <= 1'b1; z_mux_q <= 2'd1; alu_op_q <= ALU_AD; end
                  STEP_W'(4): begin stb_q[W_Y] <= 1'b1; y_mux_q <= 3'd4; end
                  STEP_W'(5): begin stb_q[W_X] <= 1'b1; x_mux_q <= 2'd3; end
                  default:    begin stb_q[W_A] <= 1'b1; a_mux_q <= 2'd1; alu_op_q <= ALU_AD; ext_flag_q <= 1'b0; end
                endcase
              end
              I_INDEX: begin
                case (step_q)
                  STEP_W'(0): begin stb_q[W_A] <= 1'b1; maddr_mux_q <= 1'b1; a_mux_q <= 2'd0; end
                  STEP_W'(1): begin stb_q[W_X] <= 1'b1; x_mux_q <= 2'd2; end
                  STEP_W'(2): begin stb_q[W_Y] <= 1'b1; y_mux_q <= 3'd2; end
                  STEP_W'(3): begin stb_q[W_B] <= 1'b1; b_mux_q <= 1'b1; alu_op_q <= ALU_AD; end
                  STEP_W'(4): begin stb_q[W_X] <= 1'b1; x_mux_q <= 2'd0; end
                  STEP_W'(5): begin stb_q[W_Y] <= 1'b1; y_mux_q <= 3'd1; end
                  STEP_W'(6): begin stb_q[W_A] <= 1'b1; a_mux_q <= 2'd1; alu_op_q <= ALU_AD; end
                  default:    begin stb_q[W_MEM] <= 1'b1; mdata_mux_q <= 1'b0; end
                endcase
              end
              I_XCH: begin
                case (step_q)
                  STEP_W'(0): begin stb_q[W_G] <= 1'b1; maddr_mux_q <= 1'b1; g_mux_q <= 1'b0; end
                  STEP_W'(1): begin stb_q[W_MEM] <= 1'b1; mdata_mux_q <= 1'b0; end
                  default:    begin stb_q[W_A] <= 1'b1; a_mux_q <= 2'd3; end
                endcase
              end
              I_CS: begin
                if (step_q == STEP_W'(0)) begin
                  stb_q[W_G] <= 1'b1; stb_q[W_A] <= 1'b1; maddr_mux_q <= 1'b1; g_mux_q <= 1'b0; a_mux_q <= 2'd0;
                end else begin
                  stb_q[W_A] <= 1'b1; a_mux_q <= 2'd2;
                end
              end
              I_TS: begin stb_q[W_MEM] <= 1'b1; mdata_mux_q <= 1'b0; end
              I_AD, I_MASK, I_SU, I_MP, I_DV: begin
                case (step_q)
                  STEP_W'(0): begin stb_q[W_X] <= 1'b1; maddr_mux_q <= 1'b1; x_mux_q <= 2'd0; end
                  STEP_W'(1): begin stb_q[W_Y] <= 1'b1; y_mux_q <= 3'd1; end
                  STEP_W'(2): begin
                    if (instr_q == I_MP || instr_q == I_DV) begin
                      stb_q[W_LP] <= 1'b1; lp_mux_q <= 1'b1; alu_op_q <= (instr_q == I_MP) ? ALU_MP0 : ALU_DV0;
                    end else begin
                      stb_q[W_A] <= 1'b1; a_mux_q <= 2'd1;
                      alu_op_q <= (instr_q == I_AD) ? ALU_AD : ((instr_q == I_MASK) ? ALU_MASK : ALU_SU);
                    end
                  end
                  default: begin
                    stb_q[W_A] <= 1'b1; a_mux_q <= 2'd1; alu_op_q <= (instr_q == I_MP) ? ALU_MP1 : ALU_DV1;
                  end
                endcase
              end
              default: ext_flag_q <= 1'b1;
            endcase
          end
          if (step_q == last_s) begin
            instr_done_q <= 1'b1;
            if (run) begin
              state_q <= S_FETCH;  wait_q <= '0;
            end else begin
              state_q <= S_IDLE;  busy_q <= 1'b0;
            end
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q <= S_IDLE;  busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agc_control_sequencer.sv
// Randomized bench for agc_control_sequencer: two configurations run side by side
// against a table-driven reference model of the instruction micro-sequences.
module tb_agc_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[2], run_s[2], stp_s[2], rdy_s[2], ext_s[2];
  logic [2:0] opc_s[2];
  logic [1:0] qc_s[2];
  logic [8:0]  stb_g[2];
  logic [18:0] mux_g[2];
  logic [3:0]  sts_g[2];

  // Instance 0: MEM_WAIT=0, halt on illegal. Instance 1: MEM_WAIT=2, pulse and refetch.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr;
    logic maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
    logic [1:0] q_mux, a_mux, x_mux, z_mux;
    logic [2:0] y_mux, alu_op;
    logic ext_flag, busy, instr_done, illegal;
    agc_control_sequencer #(.MEM_WAIT((gi == 0) ? 0 : 2), .STEP_W(4), .HALT_ON_ILLEGAL(gi == 0)) u_dut (
      .clk(clk), .reset(rst_s[gi]), .opcode(opc_s[gi]), .qc(qc_s[gi]), .extracode(ext_s[gi]),
      .mem_ready(rdy_s[gi]), .run(run_s[gi]), .step(stp_s[gi]),
      .mem_wr(mem_wr), .lp_wr(lp_wr), .g_wr(g_wr), .q_wr(q_wr), .b_wr(b_wr), .a_wr(a_wr),
      .y_wr(y_wr), .x_wr(x_wr), .z_wr(z_wr),
      .maddr_mux(maddr_mux), .mdata_mux(mdata_mux), .lp_mux(lp_mux), .g_mux(g_mux), .b_mux(b_mux),
      .q_mux(q_mux), .a_mux(a_mux), .x_mux(x_mux), .z_mux(z_mux), .y_mux(y_mux), .alu_op(alu_op),
      .ext_flag(ext_flag), .busy(busy), .instr_done(instr_done), .illegal(illegal)
    );
    assign stb_g[gi] = {mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr};
    assign mux_g[gi] = {maddr_mux, mdata_mux, lp_mux, g_mux, b_mux, q_mux, a_mux, x_mux, z_mux, y_mux, alu_op};
    assign sts_g[gi] = {ext_flag, busy, instr_done, illegal};
  end

  // Strobe bit masks and mux slots of the reference model.
  localparam logic [8:0] MEM = 9'h100, LP = 9'h080, G = 9'h040, Q = 9'h020, B = 9'h010,
                         A = 9'h008, Y = 9'h004, X = 9'h002, Z = 9'h001;
  localparam int MADDR = 0, MDATA = 1, LPM = 2, GM = 3, BM = 4, QM = 5, AM = 6, XM = 7, ZM = 8,
                 YM = 9, ALU = 10, NO = -1;
  localparam int C_TC = 0, C_CCS = 1, C_INDEX = 2, C_XCH = 3, C_CS = 4, C_TS = 5, C_AD = 6,
                 C_MASK = 7, C_SU = 8, C_MP = 9, C_DV = 10, C_EXT = 11, C_ILL = 12;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_HALT = 4;

  typedef struct packed {
    logic [8:0]  stb;
    logic [10:0] msk;
    logic [32:0] val;
    logic [1:0]  ext;   // 1 = clear ext_flag, 2 = set ext_flag
  } step_t;

  step_t      steps[2][11];
  int         nst[2], sptr[2], ph[2], wcnt[2];
  logic [2:0] mx[2][11];
  logic [8:0] e_stb[2];
  logic       e_ext[2], e_busy[2], e_done[2], e_ill[2];
  int         n_vec = 0, n_miss = 0;
  logic       run_hold[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic step_t st(input logic [8:0] stb, input int k0, input int v0,
                               input int k1, input int v1, input int k2, input int v2);
    step_t s;
    s = '0;
    s.stb = stb;
    if (k0 >= 0) begin s.msk[k0] = 1'b1; s.val[k0*3 +: 3] = 3'(v0); end
    if (k1 >= 0) begin s.msk[k1] = 1'b1; s.val[k1*3 +: 3] = 3'(v1); end
    if (k2 >= 0) begin s.msk[k2] = 1'b1; s.val[k2*3 +: 3] = 3'(v2); end
    return s;
  endfunction

  task automatic put(input int i, input step_t s, input logic [1:0] e);
    steps[i][nst[i]] = s;
    steps[i][nst[i]].ext = e;
    nst[i]++;
  endtask

  task automatic tail(input int i);
    put(i, st(X, XM, 1, NO, 0, NO, 0), 2'd1);
    put(i, st(Y, YM, 2, NO, 0, NO, 0), 2'd0);
    put(i, st(Z, ZM, 1, ALU, 0, NO, 0), 2'd0);
  endtask

  function automatic int classify(input logic [2:0] op, input logic [1:0] q, input logic ex);
    if (op == 3'd5 && q == 2'd1) return C_EXT;
    if (!ex) begin
      if (op == 3'd0) return C_TC;
      if (op == 3'd1) return C_CCS;
      if (op == 3'd4) return C_CS;
      if (op == 3'd6) return C_AD;
      if (op == 3'd7) return C_MASK;
      if (op == 3'd5) return (q == 2'd0) ? C_INDEX : ((q == 2'd2) ? C_TS : C_XCH);
      return C_ILL;
    end
    if (op == 3'd6) return C_SU;
    if (op == 3'd7) return C_MP;
    if (op == 3'd1) return C_DV;
    return C_ILL;
  endfunction

  // Expand one instruction into its list of micro-steps.
  task automatic load(input int i, input int c);
    nst[i] = 0;
    case (c)
      C_TC: begin
        put(i, st(Q, QM, 2, NO, 0, NO, 0), 2'd0); put(i, st(Z, ZM, 2, NO, 0, NO, 0), 2'd0); tail(i);
      end
      C_CCS: begin
        put(i, st(A, MADDR, 1, AM, 0, NO, 0), 2'd0); put(i, st(Y, YM, 3, NO, 0, NO, 0), 2'd0);
        put(i, st(X, XM, 2, NO, 0, NO, 0), 2'd0);    put(i, st(Z, ZM, 1, ALU, 0, NO, 0), 2'd0);
        put(i, st(Y, YM, 4, NO, 0, NO, 0), 2'd0);    put(i, st(X, XM, 3, NO, 0, NO, 0), 2'd0);
        put(i, st(A, AM, 1, ALU, 0, NO, 0), 2'd1);
      end
      C_INDEX: begin
        put(i, st(A, MADDR, 1, AM, 0, NO, 0), 2'd0); put(i, st(X, XM, 2, NO, 0, NO, 0), 2'd0);
        put(i, st(Y, YM, 2, NO, 0, NO, 0), 2'd0);    put(i, st(B, BM, 1, ALU, 0, NO, 0), 2'd0);
        put(i, st(X, XM, 0, NO, 0, NO, 0), 2'd0);    put(i, st(Y, YM, 1, NO, 0, NO, 0), 2'd0);
        put(i, st(A, AM, 1, ALU, 0, NO, 0), 2'd0);   put(i, st(MEM, MDATA, 0, NO, 0, NO, 0), 2'd0);
        tail(i);
      end
      C_XCH: begin
        put(i, st(G, MADDR, 1, GM, 0, NO, 0), 2'd0); put(i, st(MEM, MDATA, 0, NO, 0, NO, 0), 2'd0);
        put(i, st(A, AM, 3, NO, 0, NO, 0), 2'd0);    tail(i);
      end
      C_CS: begin
        put(i, st(G | A, MADDR, 1, GM, 0, AM, 0), 2'd0); put(i, st(A, AM, 2, NO, 0, NO, 0), 2'd0); tail(i);
      end
      C_TS: begin
        put(i, st(MEM, MDATA, 0, NO, 0, NO, 0), 2'd0); tail(i);
      end
      C_AD, C_MASK, C_SU: begin
        put(i, st(X, MADDR, 1, XM, 0, NO, 0), 2'd0); put(i, st(Y, YM, 1, NO, 0, NO, 0), 2'd0);
        put(i, st(A, AM, 1, ALU, (c == C_AD) ? 0 : ((c == C_MASK) ? 2 : 1), NO, 0), 2'd0);
        tail(i);
      end
      C_MP, C_DV: begin
        put(i, st(X, MADDR, 1, XM, 0, NO, 0), 2'd0); put(i, st(Y, YM, 1, NO, 0, NO, 0), 2'd0);
        put(i, st(LP, LPM, 1, ALU, (c == C_MP) ? 3 : 5, NO, 0), 2'd0);
        put(i, st(A, AM, 1, ALU, (c == C_MP) ? 4 : 6, NO, 0), 2'd0);
        tail(i);
      end
      default: put(i, st(9'h000, NO, 0, NO, 0, NO, 0), 2'd2);
    endcase
  endtask

  // Predict instance i's outputs after the coming clock edge from its current inputs.
  task automatic model(input int i);
    step_t s;
    int c;
    int mw;
    mw = (i == 0) ? 0 : 2;
    e_stb[i] = 9'h000;
    e_done[i] = 1'b0;
    if (i == 1) e_ill[i] = 1'b0;
    if (rst_s[i]) begin
      ph[i] = P_IDLE; wcnt[i] = 0; e_ext[i] = 1'b0; e_busy[i] = 1'b0; e_ill[i] = 1'b0;
      for (int k = 0; k < 11; k++) mx[i][k] = 3'd0;
    end else begin
      case (ph[i])
        P_IDLE: if (run_s[i] || stp_s[i]) begin ph[i] = P_FETCH; wcnt[i] = 0; end
        P_FETCH: begin
          if (wcnt[i] >= mw && rdy_s[i]) begin
            e_stb[i] = B; mx[i][MADDR] = 3'd0; mx[i][BM] = 3'd0; ph[i] = P_DEC;
          end else wcnt[i]++;
        end
        P_DEC: begin
          c = classify(opc_s[i], qc_s[i], ext_s[i]);
          if (c == C_ILL) begin
            e_ill[i] = 1'b1;
            if (i == 0) ph[i] = P_HALT;
            else begin ph[i] = P_FETCH; wcnt[i] = 0; end
          end else begin
            load(i, c); sptr[i] = 0; ph[i] = P_EXEC;
          end
        end
        P_EXEC: begin
          s = steps[i][sptr[i]];
          e_stb[i] = s.stb;
          for (int k = 0; k < 11; k++) if (s.msk[k]) mx[i][k] = s.val[k*3 +: 3];
          if (s.ext == 2'd1) e_ext[i] = 1'b0;
          if (s.ext == 2'd2) e_ext[i] = 1'b1;
          sptr[i]++;
          if (sptr[i] == nst[i]) begin
            e_done[i] = 1'b1;
            ph[i] = run_s[i] ? P_FETCH : P_IDLE;
            wcnt[i] = 0;
          end
        end
        default: ph[i] = P_HALT;
      endcase
      e_busy[i] = (ph[i] == P_FETCH) || (ph[i] == P_DEC) || (ph[i] == P_EXEC);
    end
  endtask

  // Advance one clock: predict, let the DUTs clock, then compare on the falling edge.
  task automatic tick();
    logic [18:0] em;
    for (int i = 0; i < 2; i++) model(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      em = {mx[i][MADDR][0], mx[i][MDATA][0], mx[i][LPM][0], mx[i][GM][0], mx[i][BM][0],
            mx[i][QM][1:0], mx[i][AM][1:0], mx[i][XM][1:0], mx[i][ZM][1:0], mx[i][YM], mx[i][ALU]};
      check($sformatf("u%0d.strobes", i), {23'd0, stb_g[i]}, {23'd0, e_stb[i]});
      check($sformatf("u%0d.selects", i), {13'd0, mux_g[i]}, {13'd0, em});
      check($sformatf("u%0d.status", i), {28'd0, sts_g[i]},
            {28'd0, e_ext[i], e_busy[i], e_done[i], e_ill[i]});
    end
  endtask

  task automatic drive(input logic r, input logic rn, input logic sp, input logic rd,
                       input logic [2:0] op, input logic [1:0] q, input logic ex);
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = r; run_s[i] = rn; stp_s[i] = sp; rdy_s[i] = rd;
      opc_s[i] = op; qc_s[i] = q; ext_s[i] = ex;
    end
  endtask

  task automatic rand_instr(input int i);
    int k;
    k = $urandom_range(0, 12);
    qc_s[i] = 2'($urandom_range(0, 3));
    ext_s[i] = 1'b0;
    case (k)
      0: opc_s[i] = 3'd0;
      1: opc_s[i] = 3'd1;
      2: opc_s[i] = 3'd4;
      3: opc_s[i] = 3'd6;
      4: opc_s[i] = 3'd7;
      5: begin opc_s[i] = 3'd5; qc_s[i] = 2'd0; end
      6: begin opc_s[i] = 3'd5; qc_s[i] = 2'd2; end
      7: begin opc_s[i] = 3'd5; qc_s[i] = 2'd3; end
      8: begin opc_s[i] = 3'd5; qc_s[i] = 2'd1; ext_s[i] = 1'($urandom_range(0, 1)); end
      9: begin opc_s[i] = 3'd6; ext_s[i] = 1'b1; end
      10: begin opc_s[i] = 3'd7; ext_s[i] = 1'b1; end
      11: begin opc_s[i] = 3'd1; ext_s[i] = 1'b1; end
      default: begin opc_s[i] = 3'($urandom_range(0, 7)); ext_s[i] = 1'($urandom_range(0, 1)); end
    endcase
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0);
    repeat (2) tick();
    // Free-running AD back to back.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 2'd0, 1'b0);
    repeat (20) tick();
    // EXTEND (repeated) followed by MP.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 2'd1, 1'b0);
    repeat (6) tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 2'd0, 1'b1);
    repeat (14) tick();
    // Memory not ready for several cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 2'd0, 1'b0);
    repeat (5) tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 2'd0, 1'b0);
    repeat (12) tick();
    // Single-step one INDEX from IDLE.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
    repeat (25) tick();
    // Illegal opcode 2.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 2'd0, 1'b0);
    repeat (12) tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
    tick();
    // Reset in the middle of an INDEX.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
    repeat (7) tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd0, 1'b0);
    repeat (5) tick();
    // Random traffic.
    run_hold[0] = 1'b1;
    run_hold[1] = 1'b1;
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 29) == 0) run_hold[i] = ~run_hold[i];
        rst_s[i] = ($urandom_range(0, 149) == 0);
        run_s[i] = run_hold[i];
        stp_s[i] = ($urandom_range(0, 7) == 0);
        rdy_s[i] = ($urandom_range(0, 3) != 0);
        rand_instr(i);
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/agc_control_sequencer.md
Name: agc_control_sequencer

Overview:
- Parametrised next-generation control-pulse sequencer for the AGC datapath.
- Fetches an instruction word into B, decodes opcode/qc/extracode and issues one register-write strobe per cycle, with mux selects and alu_op, to execute the instruction.
- Adds features the previous sequencer lacks: synchronous reset, variable memory wait states with a ready handshake, run/single-step control, illegal-opcode detection, and status outputs (busy, instr_done).

Parameters:
MEM_WAIT, 0, minimum number of extra cycles FETCH waits before the B load is allowed.
STEP_W, 4, width of the execution step counter; must cover 11 steps.
HALT_ON_ILLEGAL, 1, 1 = illegal opcode enters HALT until reset; 0 = flag it and refetch.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
opcode  in  3  instruction opcode field, from B
qc  in  2  quarter-code field
extracode  in  1  extended-opcode qualifier
mem_ready  in  1  memory read data valid
run  in  1  free-run enable
step  in  1  single-instruction request, one-cycle pulse
mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr  out  1 each  one-cycle write strobes
maddr_mux, mdata_mux, lp_mux, g_mux, b_mux  out  1 each  selects
q_mux, a_mux, x_mux, z_mux  out  2 each  selects
y_mux, alu_op  out  3 each  select / ALU op (AD=0 SU=1 MASK=2 MP0=3 MP1=4 DV0=5 DV1=6)
ext_flag  out  1  extracode latch
busy  out  1  high in any state other than IDLE or HALT
instr_done  out  1  one-cycle pulse on the last step of each instruction
illegal  out  1  pulse (HALT_ON_ILLEGAL=0) or sticky level (=1) on an undecodable instruction

Behaviour:
- Reset (synchronous, active-high; also when asserted mid-instruction):
  - Next cycle all outputs are 0 and state is IDLE. This includes ext_flag, the step counter and the wait counter.
  - No partial sequence completes.
- All outputs are registered.
- Strobes default to 0 each cycle.
- Muxes and alu_op hold their last value until rewritten. Each is written in the same cycle as the strobe that uses it.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - If run=1 or step=1, go to FETCH.
  - The step request is consumed, so exactly one instruction runs before returning to IDLE unless run=1.
- FETCH:
  - The wait counter counts up from 0.
  - When count ≥ MEM_WAIT and mem_ready=1, assert b_wr with maddr_mux=0 and b_mux=0, then go to DECODE.
  - Otherwise hold. mem_ready low stalls indefinitely.
- DECODE (1 cycle), priority top-down:
  - opcode 5, qc 1 → EXTEND (extracode ignored).
  - extracode=0:
    - opcode 0 → TC; 1 → CCS; 4 → CS; 6 → AD; 7 → MASK.
    - opcode 5: qc 0 → INDEX; qc 2 → TS; qc 3 → XCH.
  - extracode=1: opcode 6 → SU; 7 → MP; 1 → DV.
  - Anything else is illegal. With HALT_ON_ILLEGAL=1, go to HALT with illegal=1 until reset. Otherwise pulse illegal for 1 cycle and go to FETCH.
- EXEC: one step per cycle, step counter from 0.
  - TAIL = x_wr(x_mux1), y_wr(y_mux2), z_wr(z_mux1, AD). ext_flag is cleared on the first TAIL step.
  - Last step: assert instr_done, then go to FETCH if run=1, else IDLE.
  - TC: q_wr(q2); z_wr(z2); TAIL. 5 steps.
  - CCS: a_wr(maddr1, a0); y_wr(y3); x_wr(x2); z_wr(z1, AD); y_wr(y4); x_wr(x3); a_wr(a1, AD). 7 steps, ext_flag cleared on step 6.
  - INDEX: a_wr(maddr1, a0); x_wr(x2); y_wr(y2); b_wr(b1, AD); x_wr(x0); y_wr(y1); a_wr(a1, AD); mem_wr(mdata0); TAIL. 11 steps.
  - XCH: g_wr(maddr1, g0); mem_wr(mdata0); a_wr(a3); TAIL. 6 steps.
  - CS: g_wr and a_wr together (maddr1, g0, a0); a_wr(a2); TAIL. 5 steps.
  - TS: mem_wr(mdata0); TAIL. 4 steps.
  - AD/MASK/SU: x_wr(maddr1, x0); y_wr(y1); a_wr(a1, op = AD/MASK/SU); TAIL. 6 steps.
  - MP/DV: x_wr(maddr1, x0); y_wr(y1); lp_wr(lp1, MP0/DV0); a_wr(a1, MP1/DV1); TAIL. 7 steps.
  - EXTEND: 1 step. ext_flag←1, no strobes, instr_done.
- ext_flag persists across the following fetch and decode.
- Two consecutive EXTENDs are legal; ext_flag stays 1.
- run deasserted mid-instruction: the instruction completes, then the block goes to IDLE.

Test Plan:
- Reset then run=1, MEM_WAIT=0, mem_ready=1, opcode 6, extracode 0 → cycle 1: b_wr. Cycle 2: decode. Cycles 3–8: x_wr, y_wr, a_wr (alu_op 0), x_wr, y_wr, z_wr. instr_done in cycle 8, b_wr again in cycle 9.
- EXTEND (opcode 5, qc 1) then opcode 7, extracode 1 → ext_flag=1 after EXTEND. MP sequence with lp_wr at alu_op 3 and a_wr at alu_op 4. ext_flag returns to 0 on MP step 4.
- MEM_WAIT=2, mem_ready held low 5 cycles → no b_wr while ready is low. b_wr in the first cycle with ready=1 and count ≥ 2. busy=1 throughout.
- run=0 with one step pulse, INDEX → exactly 11 EXEC strobes, mem_wr on step 7, instr_done, return to IDLE with busy=0 and no further b_wr.
- opcode 2, extracode 0 → HALT_ON_ILLEGAL=1: illegal stays 1, no strobes until reset. HALT_ON_ILLEGAL=0: 1-cycle illegal pulse, then b_wr.
- Reset asserted at INDEX step 4 → next cycle all strobes 0, ext_flag 0, busy 0. No mem_wr ever issued.
